// File: rtl/count_ctrl_pkg.sv
// Shared types for the count_ctrl run-control stage:
// FSM state encoding and run-mode encoding.
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    typedef enum logic {
        FREE_RUN = 1'b0,
        ONE_SHOT = 1'b1
    } mode_t;

endpackage

// File: rtl/count_ctrl_tick_prescaler.sv
// tick_prescaler: free-running divider that raises tick for one cycle
// every PRESCALE cycles.
// Ports: clock, reset (async active-low), clear (sync zero),
//        hold (freeze), tick (combinational, one cycle per wrap).
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    // Tick is qualified so a cleared or held divider never fires.
    assign tick = !clear && !hold && (cnt == LAST);

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: run-control stage driving the downstream counter enable.
// Ports: clock, reset (async active-low), start/stop/step commands,
//        mode (0 free-run, 1 one-shot), target (one-shot pulse count),
//        enable/busy/done (registered outputs).
// Optional: COUNT_CTRL_PAUSE_EN adds input pause (freezes a run).
module count_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             step,
    input  logic             mode,
    input  logic [WIDTH-1:0] target,
`ifdef COUNT_CTRL_PAUSE_EN
    input  logic             pause,
`endif
    output logic             enable,
    output logic             busy,
    output logic             done
);

    state_t           state, state_n;
    mode_t            mode_q, mode_n;
    logic [WIDTH-1:0] target_q, target_n;
    logic [WIDTH-1:0] pcnt, pcnt_n;
    logic             tick;
    logic             paused;
    logic             complete;
    logic             ps_clear;
    logic             enable_n, done_n, busy_n;

`ifdef COUNT_CTRL_PAUSE_EN
    assign paused = (state == RUN) && pause;
`else
    assign paused = 1'b0;
`endif

    // Outside RUN the divider sits at zero, so a new run always
    // waits a full PRESCALE period before its first pulse.
    assign ps_clear = (state != RUN);

    assign complete = (state == RUN) && (mode_q == ONE_SHOT)
                   && (pcnt == target_q);

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_ps (
        .clock(clock),
        .reset(reset),
        .clear(ps_clear),
        .hold (paused),
        .tick (tick)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mode_q   <= FREE_RUN;
            target_q <= '0;
            pcnt     <= '0;
            enable   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            mode_q   <= mode_n;
            target_q <= target_n;
            pcnt     <= pcnt_n;
            enable   <= enable_n;
            busy     <= busy_n;
            done     <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        mode_n   = mode_q;
        target_n = target_q;
        pcnt_n   = pcnt;
        unique case (state)
            IDLE: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (start) begin
                    state_n  = RUN;
                    mode_n   = mode_t'(mode);
                    target_n = target;
                    pcnt_n   = '0;
                end else if (step) begin
                    state_n = STEP;
                end
            end
            RUN: begin
                if (stop) begin
                    state_n = IDLE;
                end else if (paused) begin
                    state_n = RUN;
                end else if (complete) begin
                    state_n = IDLE;
                end else if (tick && (mode_q == ONE_SHOT)) begin
                    pcnt_n = pcnt + 1'b1;
                end
            end
            STEP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        enable_n = 1'b0;
        done_n   = 1'b0;
        unique case (state)
            RUN: begin
                if (!stop && !paused) begin
                    if (complete) begin
                        done_n = 1'b1;
                    end else begin
                        enable_n = tick;
                    end
                end
            end
            STEP: begin
                enable_n = !stop;
            end
            default: begin
                enable_n = 1'b0;
            end
        endcase
        busy_n = (state_n == RUN) || (state_n == STEP);
    end

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: two instances (PRESCALE 1 and 4),
// plus a PRESCALE 2 instance when COUNT_CTRL_PAUSE_EN is defined.
module tb_count_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, step, mode;
    logic [3:0] target;
`ifdef COUNT_CTRL_PAUSE_EN
    logic       pause;
    logic       en_c, busy_c, done_c;
    int         cnt_c;
`endif
    logic       en_a, busy_a, done_a;
    logic       en_b, busy_b, done_b;
    logic       clr;
    int         cnt_a, cnt_b, dn_a, dn_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    count_ctrl #(.WIDTH(4), .PRESCALE(1)) u_a (
        .clock(clk), .reset(rst_n), .start(start), .stop(stop),
        .step(step), .mode(mode), .target(target),
`ifdef COUNT_CTRL_PAUSE_EN
        .pause(1'b0),
`endif
        .enable(en_a), .busy(busy_a), .done(done_a)
    );

    count_ctrl #(.WIDTH(4), .PRESCALE(4)) u_b (
        .clock(clk), .reset(rst_n), .start(start), .stop(stop),
        .step(step), .mode(mode), .target(target),
`ifdef COUNT_CTRL_PAUSE_EN
        .pause(1'b0),
`endif
        .enable(en_b), .busy(busy_b), .done(done_b)
    );

`ifdef COUNT_CTRL_PAUSE_EN
    count_ctrl #(.WIDTH(4), .PRESCALE(2)) u_c (
        .clock(clk), .reset(rst_n), .start(start), .stop(stop),
        .step(step), .mode(mode), .target(target),
        .pause(pause),
        .enable(en_c), .busy(busy_c), .done(done_c)
    );
`endif

    // Downstream counter models and done-pulse tallies.
    always @(posedge clk) begin
        if (clr) begin
            cnt_a <= 0;
            cnt_b <= 0;
            dn_a  <= 0;
            dn_b  <= 0;
`ifdef COUNT_CTRL_PAUSE_EN
            cnt_c <= 0;
`endif
        end else begin
            if (en_a)   cnt_a <= cnt_a + 1;
            if (en_b)   cnt_b <= cnt_b + 1;
            if (done_a) dn_a  <= dn_a + 1;
            if (done_b) dn_b  <= dn_b + 1;
`ifdef COUNT_CTRL_PAUSE_EN
            if (en_c)   cnt_c <= cnt_c + 1;
`endif
        end
    end

    task automatic clean();
        start = 1'b0;
        step  = 1'b0;
        stop  = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        clr  = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({en_a, busy_a, done_a, en_b, busy_b, done_b} !== 6'b0) begin
            errors++;
            $display("FAIL reset got %b%b%b%b%b%b want 000000",
                     en_a, busy_a, done_a, en_b, busy_b, done_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_oneshot();
        logic [2:0] exp;
        clean();
        mode   = 1'b1;
        target = 4'd5;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({en_a, busy_a, done_a} !== 3'b010) begin
            errors++;
            $display("FAIL os_start got %b want 010",
                     {en_a, busy_a, done_a});
        end
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            exp = {1'(k <= 5), 1'(k <= 5), 1'(k == 6)};
            checks++;
            if ({en_a, busy_a, done_a} !== exp) begin
                errors++;
                $display("FAIL os_cyc%0d got %b want %b",
                         k, {en_a, busy_a, done_a}, exp);
            end
        end
        @(negedge clk);
        checks++;
        if (cnt_a !== 5) begin
            errors++;
            $display("FAIL os_count got %0d want 5", cnt_a);
        end
        checks++;
        if (dn_a !== 1) begin
            errors++;
            $display("FAIL os_done_n got %0d want 1", dn_a);
        end
    endtask

    task automatic test_freerun();
        clean();
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checks++;
            if (en_b !== 1'((k % 4) == 0) || busy_b !== 1'b1) begin
                errors++;
                $display("FAIL fr_cyc%0d got en=%b busy=%b want en=%b busy=1",
                         k, en_b, busy_b, 1'((k % 4) == 0));
            end
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        checks++;
        if ({en_b, busy_b, done_b} !== 3'b000) begin
            errors++;
            $display("FAIL fr_stop got %b want 000",
                     {en_b, busy_b, done_b});
        end
        checks++;
        if (cnt_b !== 5 || dn_b !== 0) begin
            errors++;
            $display("FAIL fr_pulses got cnt=%0d done=%0d want 5 0",
                     cnt_b, dn_b);
        end
    endtask

    task automatic test_step();
        clean();
        for (int n = 0; n < 3; n++) begin
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            checks++;
            if ({en_a, busy_a} !== 2'b01) begin
                errors++;
                $display("FAIL st_enter%0d got %b want 01",
                         n, {en_a, busy_a});
            end
            @(negedge clk);
            checks++;
            if ({en_a, busy_a} !== 2'b10) begin
                errors++;
                $display("FAIL st_pulse%0d got %b want 10",
                         n, {en_a, busy_a});
            end
            @(negedge clk);
            checks++;
            if (en_a !== 1'b0) begin
                errors++;
                $display("FAIL st_after%0d got %b want 0", n, en_a);
            end
            @(negedge clk);
        end
        checks++;
        if (cnt_a !== 3 || dn_a !== 0) begin
            errors++;
            $display("FAIL st_count got cnt=%0d done=%0d want 3 0",
                     cnt_a, dn_a);
        end
    endtask

    task automatic test_zero_target();
        clean();
        mode   = 1'b1;
        target = 4'd0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if ({en_a, busy_a, done_a} !== 3'b010) begin
            errors++;
            $display("FAIL z_start got %b want 010",
                     {en_a, busy_a, done_a});
        end
        @(negedge clk);
        checks++;
        if ({en_a, busy_a, done_a} !== 3'b001) begin
            errors++;
            $display("FAIL z_done got %b want 001",
                     {en_a, busy_a, done_a});
        end
        @(negedge clk);
        checks++;
        if ({en_a, busy_a, done_a} !== 3'b000 || cnt_a !== 0) begin
            errors++;
            $display("FAIL z_idle got %b cnt=%0d want 000 0",
                     {en_a, busy_a, done_a}, cnt_a);
        end
    endtask

    task automatic test_async_reset();
        clean();
        mode  = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (en_b !== 1'b1 || en_a !== 1'b1) begin
            errors++;
            $display("FAIL ar_pre got en_a=%b en_b=%b want 1 1",
                     en_a, en_b);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en_a, busy_a, done_a, en_b, busy_b, done_b} !== 6'b0) begin
            errors++;
            $display("FAIL ar_clear got %b%b%b%b%b%b want 000000",
                     en_a, busy_a, done_a, en_b, busy_b, done_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (en_b !== 1'(k == 4)) begin
                errors++;
                $display("FAIL ar_restart%0d got %b want %b",
                         k, en_b, 1'(k == 4));
            end
        end
    endtask

`ifdef COUNT_CTRL_PAUSE_EN
    task automatic test_pause();
        logic prev_p;
        logic bad;
        logic got;
        clean();
        mode   = 1'b1;
        target = 4'd6;
        pause  = 1'b0;
        prev_p = 1'b0;
        bad    = 1'b0;
        got    = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 60 && !got; k++) begin
            @(negedge clk);
            if (prev_p && (en_c || !busy_c)) bad = 1'b1;
            if (done_c) got = 1'b1;
            pause  = (k >= 5) && (k < 12);
            prev_p = pause;
        end
        pause = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL pa_done got none want pulse");
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL pa_hold got en/busy wrong want en=0 busy=1");
        end
        checks++;
        if (cnt_c !== 6) begin
            errors++;
            $display("FAIL pa_count got %0d want 6", cnt_c);
        end
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        stop   = 1'b0;
        step   = 1'b0;
        mode   = 1'b0;
        target = 4'd0;
        clr    = 1'b1;
`ifdef COUNT_CTRL_PAUSE_EN
        pause  = 1'b0;
`endif
        test_reset();
        test_oneshot();
        test_freerun();
        test_step();
        test_zero_target();
        test_async_reset();
`ifdef COUNT_CTRL_PAUSE_EN
        test_pause();
`endif
        clean();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
